// File: rtl/wts_tone_generator_nch.sv
// N-channel wave-table phase/address generator: per-channel frequency
// divider and sample pointer, multiplexed onto one registered wave-RAM address.
module wts_tone_generator_nch #(
    parameter int CHANNELS   = 5,
    parameter int FREQ_WIDTH = 12,
    parameter int ADDR_WIDTH = 5,
    parameter int CH_BITS    = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          address_reset,
    input  logic [CHANNELS-1:0]           key_on,
    input  logic [CHANNELS-1:0]           one_shot,
    input  logic [2*CHANNELS-1:0]         reg_wave_length,
    input  logic [FREQ_WIDTH*CHANNELS-1:0] reg_frequency_count,
    input  logic [CH_BITS-1:0]            active,
    output logic [CH_BITS+ADDR_WIDTH-1:0] wave_address,
    output logic                          half_timing,
    output logic [CHANNELS-1:0]           end_flag
);

    logic [ADDR_WIDTH-1:0] addr_v [CHANNELS];
    logic [ADDR_WIDTH-1:0] last_v [CHANNELS];

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [1:0]            wl;
        logic [FREQ_WIDTH-1:0] freq;
        logic                  restart;
        logic [FREQ_WIDTH-1:0] cnt_q;
        logic [ADDR_WIDTH-1:0] addr_q;
        logic                  end_q;
        logic [ADDR_WIDTH-1:0] last;

        assign wl      = reg_wave_length[2*i +: 2];
        assign freq    = reg_frequency_count[FREQ_WIDTH*i +: FREQ_WIDTH];
        assign restart = address_reset | key_on[i];
        // Last valid index of a 2^(ADDR_WIDTH-wl) sample wave.
        assign last    = {ADDR_WIDTH{1'b1}} >> wl;

        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_q  <= '0;
                addr_q <= '0;
                end_q  <= 1'b0;
            end else if (restart) begin
                cnt_q  <= freq;
                addr_q <= '0;
                end_q  <= 1'b0;
            end else if (!end_q) begin
                if (cnt_q != '0) begin
                    cnt_q <= cnt_q - 1'b1;
                end else begin
                    cnt_q <= freq;
                    // ">=" so a wave shortened mid-run wraps cleanly.
                    if (addr_q < last) begin
                        addr_q <= addr_q + 1'b1;
                    end else if (one_shot[i]) begin
                        end_q <= 1'b1;
                    end else begin
                        addr_q <= '0;
                    end
                end
            end
        end

        assign addr_v[i]   = addr_q;
        assign last_v[i]   = last;
        assign end_flag[i] = end_q;
    end

    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [ADDR_WIDTH-1:0] sel_last;
    logic                  sel_ok;
    logic [ADDR_WIDTH:0]   half_thr;
    logic                  sel_half;

    always_comb begin
        sel_addr = '0;
        sel_last = '0;
        sel_ok   = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (active == CH_BITS'(i)) begin
                sel_addr = addr_v[i];
                sel_last = last_v[i];
                sel_ok   = 1'b1;
            end
        end
    end

    assign half_thr = ({1'b0, sel_last} + 1'b1) >> 1;
    assign sel_half = {1'b0, sel_addr} >= half_thr;

    always_ff @(posedge clk) begin
        if (reset) begin
            wave_address <= '0;
            half_timing  <= 1'b0;
        end else if (sel_ok) begin
            wave_address <= {active, sel_addr};
            half_timing  <= sel_half;
        end else begin
            wave_address <= '0;
            half_timing  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wts_tone_generator_nch.sv
// Bench for wts_tone_generator_nch: rule-level channel model checked every
// cycle, plus hand-computed literal expectations.
module tb_wts_tone_generator_nch;

    localparam int CH = 5;
    localparam int FW = 12;
    localparam int AW = 5;
    localparam int CB = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              address_reset;
    logic [CH-1:0]     key_on;
    logic [CH-1:0]     one_shot;
    logic [2*CH-1:0]   reg_wave_length;
    logic [FW*CH-1:0]  reg_frequency_count;
    logic [CB-1:0]     active;
    logic [CB+AW-1:0]  wave_address;
    logic              half_timing;
    logic [CH-1:0]     end_flag;

    int checks = 0;
    int errors = 0;

    wts_tone_generator_nch #(
        .CHANNELS(CH), .FREQ_WIDTH(FW), .ADDR_WIDTH(AW), .CH_BITS(CB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .address_reset(address_reset),
        .key_on(key_on),
        .one_shot(one_shot),
        .reg_wave_length(reg_wave_length),
        .reg_frequency_count(reg_frequency_count),
        .active(active),
        .wave_address(wave_address),
        .half_timing(half_timing),
        .end_flag(end_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: channel rules in plain integer arithmetic.
    int m_cnt [CH];
    int m_addr [CH];
    int m_end [CH];
    int exp_wa = 0;
    int exp_ht = 0;
    bit m_valid = 1'b0;

    always @(posedge clk) begin : model
        int nc [CH];
        int na [CH];
        int ne [CH];
        int a, len, fr;
        if (reset) begin
            for (int i = 0; i < CH; i++) begin
                nc[i] = 0; na[i] = 0; ne[i] = 0;
            end
            exp_wa  <= 0;
            exp_ht  <= 0;
            m_valid <= 1'b1;
        end else begin
            a = int'(active);
            if (a < CH) begin
                len = 1 << (AW - int'(reg_wave_length[2*a +: 2]));
                exp_wa <= a * (1 << AW) + m_addr[a];
                exp_ht <= (m_addr[a] >= len / 2) ? 1 : 0;
            end else begin
                exp_wa <= 0;
                exp_ht <= 0;
            end
            for (int i = 0; i < CH; i++) begin
                nc[i] = m_cnt[i]; na[i] = m_addr[i]; ne[i] = m_end[i];
                fr  = int'(reg_frequency_count[FW*i +: FW]);
                len = 1 << (AW - int'(reg_wave_length[2*i +: 2]));
                if (address_reset || key_on[i]) begin
                    nc[i] = fr; na[i] = 0; ne[i] = 0;
                end else if (m_end[i] != 0) begin
                    nc[i] = m_cnt[i];
                end else if (m_cnt[i] != 0) begin
                    nc[i] = m_cnt[i] - 1;
                end else begin
                    nc[i] = fr;
                    if (m_addr[i] < len - 1) na[i] = m_addr[i] + 1;
                    else if (one_shot[i]) ne[i] = 1;
                    else na[i] = 0;
                end
            end
        end
        m_cnt  <= nc;
        m_addr <= na;
        m_end  <= ne;
    end

    always @(negedge clk) begin : compare
        int ef;
        if (m_valid) begin
            ef = 0;
            for (int i = 0; i < CH; i++) ef |= (m_end[i] != 0) ? (1 << i) : 0;
            chk("model_wave_address", int'(wave_address), exp_wa);
            chk("model_half_timing", int'(half_timing), exp_ht);
            chk("model_end_flag", int'(end_flag), ef);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic restart_all();
        address_reset = 1'b1;
        tick(1);
        address_reset = 1'b0;
    endtask

    task automatic set_freq(input int ch, input int f);
        reg_frequency_count[FW*ch +: FW] = FW'(f);
    endtask

    initial begin
        reset = 1'b1;
        address_reset = 1'b0;
        key_on = '0;
        one_shot = '0;
        reg_wave_length = '0;
        reg_frequency_count = '0;
        active = '0;

        tick(1);
        chk("reset_wave_address", int'(wave_address), 0);
        chk("reset_half_timing", int'(half_timing), 0);
        chk("reset_end_flag", int'(end_flag), 0);
        tick(1);
        reset = 1'b0;

        // freq 0, full wave: one step per clock, wraps 31 -> 0
        restart_all();
        for (int k = 1; k <= 33; k++) begin
            tick(1);
            if (k == 1)  chk("f0_idx0", int'(wave_address[AW-1:0]), 0);
            if (k == 2)  chk("f0_idx1", int'(wave_address[AW-1:0]), 1);
            if (k == 17) chk("f0_half", int'(half_timing), 1);
            if (k == 32) chk("f0_idx31", int'(wave_address[AW-1:0]), 31);
            if (k == 33) chk("f0_wrap", int'(wave_address[AW-1:0]), 0);
        end

        // freq 1: each index held 2 clocks
        set_freq(0, 1);
        restart_all();
        tick(2);
        chk("f1_hold0", int'(wave_address[AW-1:0]), 0);
        tick(1);
        chk("f1_idx1", int'(wave_address[AW-1:0]), 1);
        tick(2);
        chk("f1_idx2", int'(wave_address[AW-1:0]), 2);
        tick(70);

        // freq 2: each index held 3 clocks
        set_freq(0, 2);
        restart_all();
        tick(3);
        chk("f2_hold0", int'(wave_address[AW-1:0]), 0);
        tick(1);
        chk("f2_idx1", int'(wave_address[AW-1:0]), 1);
        tick(100);

        // quarter wave, half_timing on 4..7, shrink to 1/8 at index 6
        set_freq(0, 0);
        reg_wave_length[1:0] = 2'd2;
        restart_all();
        tick(4);
        chk("wl2_idx3", int'(wave_address[AW-1:0]), 3);
        chk("wl2_half_lo", int'(half_timing), 0);
        tick(1);
        chk("wl2_idx4", int'(wave_address[AW-1:0]), 4);
        chk("wl2_half_hi", int'(half_timing), 1);
        tick(1);
        reg_wave_length[1:0] = 2'd3;
        tick(1);
        chk("wl3_idx6", int'(wave_address[AW-1:0]), 6);
        tick(1);
        chk("wl3_wrap", int'(wave_address[AW-1:0]), 0);
        tick(10);
        reg_wave_length[1:0] = 2'd0;

        // one-shot on channel 1, 1/8 wave
        reg_wave_length[3:2] = 2'd3;
        one_shot[1] = 1'b1;
        active = 3'd1;
        key_on[1] = 1'b1;
        tick(1);
        key_on[1] = 1'b0;
        tick(3);
        chk("os_end_lo", int'(end_flag[1]), 0);
        tick(2);
        chk("os_end_hi", int'(end_flag[1]), 1);
        chk("os_hold", int'(wave_address), 8'h23);
        tick(5);
        one_shot[1] = 1'b0;
        tick(3);
        chk("os_sticky", int'(end_flag[1]), 1);
        key_on[1] = 1'b1;
        tick(1);
        key_on[1] = 1'b0;
        chk("os_release", int'(end_flag[1]), 0);
        tick(1);
        chk("os_restart", int'(wave_address), 8'h20);
        tick(4);

        // active sweep with distinct freqs; simultaneous restarts
        for (int i = 0; i < CH; i++) set_freq(i, i);
        reg_wave_length = '0;
        address_reset = 1'b1;
        key_on = '1;
        tick(1);
        address_reset = 1'b0;
        key_on = '0;
        for (int c = 0; c < 40; c++) begin
            active = CB'(c % 8);
            tick(1);
        end
        active = 3'd3;
        tick(1);
        chk("act3_field", int'(wave_address[CB+AW-1:AW]), 3);
        active = 3'd6;
        tick(1);
        chk("act6_addr", int'(wave_address), 0);
        chk("act6_half", int'(half_timing), 0);

        // reset mid-run at index 17
        active = 3'd0;
        set_freq(0, 0);
        restart_all();
        tick(17);
        chk("mid_idx16", int'(wave_address[AW-1:0]), 16);
        reset = 1'b1;
        tick(1);
        chk("mid_rst_addr", int'(wave_address), 0);
        chk("mid_rst_half", int'(half_timing), 0);
        chk("mid_rst_end", int'(end_flag), 0);
        reset = 1'b0;
        tick(2);
        chk("mid_first_step", int'(wave_address), 1);
        tick(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wts_tone_generator_nch.md
# wts_tone_generator_nch

Parametrised N-channel phase/address generator for the wave-table sound core, the generalised successor of the fixed 5-channel tone generator. Each channel runs its own frequency divider and wave-RAM read pointer. The block supports selectable wave length, per-channel key-on restart and a per-channel one-shot mode. A channel selector time-multiplexes the per-channel pointers onto a single registered wave-RAM address toward the wave memory and mixer.

## Interface
- CHANNELS, 5: number of channels, 1..8
- FREQ_WIDTH, 12: frequency count width
- ADDR_WIDTH, 5: sample index width; full wave = 2^ADDR_WIDTH samples; minimum 3
- CH_BITS, 3: channel field width; must satisfy 2^CH_BITS >= CHANNELS

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high reset
- address_reset  in  1  restarts all channels
- key_on  in  CHANNELS  per-channel restart, bit i = channel i
- one_shot  in  CHANNELS  1 = channel stops at last sample; 0 = loops
- reg_wave_length  in  2*CHANNELS  packed; channel i at [2i+1:2i]
- reg_frequency_count  in  FREQ_WIDTH*CHANNELS  packed; channel i at [FREQ_WIDTH*i +: FREQ_WIDTH]
- active  in  CH_BITS  channel selected for output
- wave_address  out  CH_BITS+ADDR_WIDTH  {channel, sample index}, registered
- half_timing  out  1  selected channel is in second half of its wave, registered
- end_flag  out  CHANNELS  one-shot channel has reached its last sample

## Operation
- Per channel i, the state is a down-counter cnt_i (FREQ_WIDTH), a pointer addr_i (ADDR_WIDTH) and end_i.
- Wave length L_i = 2^(ADDR_WIDTH - wl_i), where wl_i = reg_wave_length channel i:
  - 0 = full, 1 = 1/2, 2 = 1/4, 3 = 1/8.
- Per clock, the first matching rule applies:
  1. Restart (address_reset or key_on[i]): cnt_i <= freq_i, addr_i <= 0, end_i <= 0.
  2. end_i = 1: hold all state.
  3. cnt_i != 0: cnt_i <= cnt_i - 1.
  4. cnt_i == 0: cnt_i <= freq_i, and addr_i steps as follows:
     - addr_i < L_i-1: addr_i <= addr_i + 1.
     - addr_i >= L_i-1, loop mode: addr_i <= 0.
     - addr_i >= L_i-1, one-shot: addr_i held, end_i <= 1.
- Step period is freq_i + 1 clocks. freq = 0 steps every clock.
- Frequency and wave-length changes take effect at the next reload or step. No pointer glitch occurs.
- Using ">=" in the wrap test makes shrinking L mid-run wrap to 0 on the next step.
- Clearing one_shot[i] while end_i = 1 does not release the channel. Only a restart clears end_i.
- end_flag[i] = end_i, driven directly from the register.
- Output register, updated every clock:
  - If active < CHANNELS: wave_address <= {active, addr_active}, and half_timing <= (addr_active >= L_active/2).
  - If active >= CHANNELS: both outputs <= 0.

## Timing
- Reset: all cnt, addr and end are 0, so wave_address = 0, half_timing = 0 and end_flag = 0 on the first edge with reset high. Reset overrides restart.
- Reset mid-operation: all channels return to 0 on that edge. The first step after release happens at edge 1, because cnt is 0.
- Restart latency: addr_i = 0 after the restart edge. First increment comes freq_i + 1 edges later.
- Output latency: wave_address/half_timing reflect the active value and pointer state sampled at the previous edge, i.e. one clock.
- address_reset and key_on simultaneous: identical restart, no conflict.
- Restart while end_i = 1: resumes normally.

## Test plan
- freq_0 = 0, wl = 0, pulse address_reset, active = 0 -> wave_address low field sequence 0,1,2,…,31,0, one step per clock.
- freq_0 = 1 -> each index held 2 clocks. freq_0 = 2 -> each index held 3 clocks. Wraps 31 -> 0.
- wl_0 = 2, freq 0 -> sequence 0..7,0. half_timing is 1 exactly for indices 4..7. Switching wl to 3 while addr = 6 -> next value 0.
- one_shot[1] = 1, wl = 3, freq 0, key_on[1] -> addr reaches 3, holds, end_flag[1] rises, other channels continue. A second key_on[1] -> addr 0, end_flag[1] = 0.
- CHANNELS = 5, active cycling 0..7 with distinct freqs -> wave_address upper field equals the prior active for 0..4. active = 5..7 -> wave_address = 0, half_timing = 0.
- Assert reset mid-run with addr = 17 -> next edge all outputs 0. After release, address increments on the first edge (freq 0).
